othello_board_engine: RTL and testbench
=======================================

// Module: othello_board_engine
// PURPOSE
//  Parametrised NxN Othello board store plus move engine. Checks a move in all 8 directions.
//  On a place command, writes the disk, flips every bracketed line and keeps running disk counts.
//  Sits between the game-control FSM (command side) and the VGA plotter (independent read port).
// PARAMETERS
//  N   8            board edge length; even, >=4
//  CW  $clog2(N)    coordinate width
//  NW  $clog2(N*N+1) disk-count width
// PORTS
//  clock      in   1   system clock, rising edge
//  resetn     in   1   asynchronous, active-low reset
//  cmd_valid  in   1   command request
//  cmd_ready  out  1   engine idle, command accepted when cmd_valid&&cmd_ready
//  cmd_place  in   1   0 = check only, 1 = check then place/flip if legal
//  cmd_clear  in   1   re-initialise board (has priority over cmd_place)
//  side       in   2   mover colour: 2'd2 or 2'd3; opponent = {1'b1,~side[0]}
//  x, y       in   CW  target column/row; cell index = y*N+x
//  done       out  1   one-cycle pulse when a command completes
//  legal      out  1   move legal (valid from done until next accept)
//  dir        out  8   bracketing dirs: b0 up, b1 up-right, b2 right, b3 down-right,
//                      b4 down, b5 down-left, b6 left, b7 up-left
//  flips      out  NW  disks flipped by last place (0 for check/illegal)
//  count2     out  NW  number of cells == 2
//  count3     out  NW  number of cells == 3
//  rd_x,rd_y  in   CW  plotter read address
//  rd_q       out  2   cell at (rd_x,rd_y), combinational, valid in every state
// BEHAVIOUR
//  Cell codes: 00 empty, 2/3 disks; 01 never written.
//  Reset/clear board state:
//   all cells empty except (N/2-1,N/2-1)=2, (N/2,N/2-1)=3, (N/2-1,N/2)=3, (N/2,N/2)=2.
//  Reset outputs: count2=count3=2, cmd_ready=1, done=0, legal=0, dir=0, flips=0.
//  Async reset aborts any operation immediately; partial flips are discarded with the board.
//  Commands and x/y/side are latched at accept; inputs are ignored while busy (cmd_ready=0).
//  FSM: IDLE -> CHECK -> (FLIP) -> PUT -> FIN -> IDLE; cmd_clear: IDLE -> FIN in 1 cycle.
//  IDLE: cmd_ready=1. On accept, clear dir/flips/legal and go to CHECK with d=0, k=1.
//  CHECK: examines one cell per cycle at target + k*delta(d).
//   - Target occupied or side not in {2,3}: dir=0, legal=0, go to FIN (1 CHECK cycle).
//   - Off-board or empty: direction d fails.
//   - Own disk with k=1: direction d fails.
//   - Opponent disk: k++.
//   - Own disk with k>=2: dir[d]<=1.
//   - Direction end: d++, k=1; after d=7, legal=|dir.
//   - Next state: FLIP if cmd_place&&legal, else FIN.
//   - Edge wrap is forbidden: bounds are tested on x/y separately, never on the index.
//  FLIP: for each d with dir[d]=1, ascending.
//   - Write side to each opponent cell from k=1 until the first own disk: one cell/cycle, flips++.
//   - Count update per flip: mover count +1, opponent count -1, same cycle.
//  PUT: write side at target; mover count +1.
//  FIN: done=1 for one cycle, then IDLE; cmd_ready returns high the cycle after done.
//  Latency:
//   - check: 1 + sum over d of cells examined (<= 8*(N-1)) + 1 (FIN).
//   - place adds flips+1 cycles.
//  Illegal place: board and counts unchanged, flips=0, legal=0.
//  Invariant: count2+count3 = number of non-empty cells; never exceeds N*N.
// TESTING
//  T1 reset: rd_q at (3,3)=2, (4,3)=3, (3,4)=3, (4,4)=2, others 0; count2=count3=2.
//  T2 check (2,3) side=3 -> legal=1, dir=8'h04, flips=0, board unchanged.
//  T3 place (2,3) side=3 -> flips=1; (3,3),(2,3) read 3; count3=4, count2=1.
//  T4 check (0,0) side=3 -> legal=0, dir=0; place on occupied (4,4) -> legal=0, board unchanged.
//  T5 edge wrap: after T3, place (7,2) side=2 -> must not wrap to row 3; legal=0.
//  T6 resetn low during FLIP of multi-direction move -> board = initial, counts 2/2, ready=1.
//  T7 cmd_valid held during busy ignored; done exactly one pulse; cmd_clear -> initial board.

Source files
------------

// File: rtl/othello_board_engine.sv
// NxN Othello board store with a move engine: probes the 8 rays from a target cell one
// cell per cycle, optionally flips bracketed lines and places the disk, tracking disk counts.
module othello_board_engine #(
  parameter int N  = 8,
  parameter int CW = $clog2(N),
  parameter int NW = $clog2(N*N+1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_place,
  input  logic          cmd_clear,
  input  logic [1:0]    side,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  output logic          done,
  output logic          legal,
  output logic [7:0]    dir,
  output logic [NW-1:0] flips,
  output logic [NW-1:0] count2,
  output logic [NW-1:0] count3,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  output logic [1:0]    rd_q
);

  localparam int IW = $clog2(N*N);
  localparam int KW = CW + 1;
  localparam int PW = CW + 3;
  localparam int H  = N / 2;
  localparam int CELL2A = (H-1)*N + (H-1);
  localparam int CELL2B = H*N + H;
  localparam int CELL3A = (H-1)*N + H;
  localparam int CELL3B = H*N + (H-1);

  typedef enum logic [2:0] {IDLE, CHECK, FLIP, PUT, FIN} state_e;

  state_e        state_q, state_d;
  logic [1:0]    board_q [N*N];
  logic          place_q;
  logic [1:0]    side_q;
  logic [CW-1:0] tx_q, ty_q;
  logic [2:0]    d_q, d_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    dir_q, dir_d;
  logic          legal_q, legal_d;
  logic [NW-1:0] flips_q, flips_d;
  logic [NW-1:0] count2_q, count2_d;
  logic [NW-1:0] count3_q, count3_d;

  logic          accept, initBoard, wrEn, dirEnd;
  logic [IW-1:0] wrIdx, tgtIdx, rdIdx;
  logic [IW:0]   curP, nxtP;
  logic [1:0]    tgtCell, curCell, nxtCell, opp;
  logic [7:0]    dirNew, rest;

  // Bounds are checked on x and y separately so a ray never wraps onto the next row.
  function automatic logic [IW:0] probe(input logic [2:0] dd, input logic [KW-1:0] kk,
                                        input logic [CW-1:0] px0, input logic [CW-1:0] py0);
    logic signed [PW-1:0] sk, px, py;
    logic                 onb;
    logic [IW-1:0]        idx;
    sk = signed'({{(PW-KW){1'b0}}, kk});
    px = signed'({{(PW-CW){1'b0}}, px0});
    py = signed'({{(PW-CW){1'b0}}, py0});
    case (dd)
      3'd0: py = py - sk;
      3'd1: begin py = py - sk; px = px + sk; end
      3'd2: px = px + sk;
      3'd3: begin py = py + sk; px = px + sk; end
      3'd4: py = py + sk;
      3'd5: begin py = py + sk; px = px - sk; end
      3'd6: px = px - sk;
      default: begin py = py - sk; px = px - sk; end
    endcase
    onb = (px[PW-1] == 1'b0) && (px < PW'(N)) && (py[PW-1] == 1'b0) && (py < PW'(N));
    idx = IW'(py[CW-1:0]) * IW'(N) + IW'(px[CW-1:0]);
    return {onb, idx};
  endfunction

  function automatic logic [2:0] lowestSet(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [1:0] initCell(input int i);
    if (i == CELL2A || i == CELL2B) return 2'd2;
    if (i == CELL3A || i == CELL3B) return 2'd3;
    return 2'd0;
  endfunction

  assign tgtIdx  = IW'(ty_q) * IW'(N) + IW'(tx_q);
  assign rdIdx   = IW'(rd_y) * IW'(N) + IW'(rd_x);
  assign curP    = probe(d_q, k_q, tx_q, ty_q);
  assign nxtP    = probe(d_q, k_q + KW'(1), tx_q, ty_q);
  assign tgtCell = board_q[tgtIdx];
  assign curCell = curP[IW] ? board_q[curP[IW-1:0]] : 2'b00;
  assign nxtCell = nxtP[IW] ? board_q[nxtP[IW-1:0]] : 2'b00;
  assign opp     = {1'b1, ~side_q[0]};
  assign rd_q    = board_q[rdIdx];

  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == FIN);
  assign legal     = legal_q;
  assign dir       = dir_q;
  assign flips     = flips_q;
  assign count2    = count2_q;
  assign count3    = count3_q;

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    k_d       = k_q;
    dir_d     = dir_q;
    legal_d   = legal_q;
    flips_d   = flips_q;
    count2_d  = count2_q;
    count3_d  = count3_q;
    accept    = 1'b0;
    initBoard = 1'b0;
    wrEn      = 1'b0;
    wrIdx     = tgtIdx;
    dirEnd    = 1'b0;
    dirNew    = dir_q;
    rest      = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          dir_d   = '0;
          flips_d = '0;
          legal_d = 1'b0;
          d_d     = '0;
          k_d     = KW'(1);
          if (cmd_clear) begin
            initBoard = 1'b1;
            count2_d  = NW'(2);
            count3_d  = NW'(2);
            state_d   = FIN;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (tgtCell != 2'b00 || !side_q[1]) begin
          dir_d   = '0;
          legal_d = 1'b0;
          state_d = FIN;
        end else begin
          if (curP[IW] && curCell == opp) begin
            k_d = k_q + KW'(1);
          end else begin
            dirEnd = 1'b1;
            if (curP[IW] && curCell == side_q && k_q >= KW'(2)) dirNew[d_q] = 1'b1;
          end
          dir_d = dirNew;
          if (dirEnd) begin
            k_d = KW'(1);
            if (d_q == 3'd7) begin
              legal_d = |dirNew;
              if (place_q && |dirNew) begin
                state_d = FLIP;
                d_d     = lowestSet(dirNew);
              end else begin
                state_d = FIN;
              end
            end else begin
              d_d = d_q + 3'd1;
            end
          end
        end
      end
      // Looking one cell ahead ends each ray without spending a cycle on the closing own disk.
      FLIP: begin
        wrEn    = 1'b1;
        wrIdx   = curP[IW-1:0];
        flips_d = flips_q + NW'(1);
        if (side_q[0]) begin
          count3_d = count3_q + NW'(1);
          count2_d = count2_q - NW'(1);
        end else begin
          count2_d = count2_q + NW'(1);
          count3_d = count3_q - NW'(1);
        end
        rest = dir_q & (8'hFE << d_q);
        if (nxtP[IW] && nxtCell == opp) begin
          k_d = k_q + KW'(1);
        end else begin
          k_d = KW'(1);
          if (rest != 8'h00) d_d = lowestSet(rest);
          else               state_d = PUT;
        end
      end
      PUT: begin
        wrEn  = 1'b1;
        wrIdx = tgtIdx;
        if (side_q[0]) count3_d = count3_q + NW'(1);
        else           count2_d = count2_q + NW'(1);
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      place_q  <= 1'b0;
      side_q   <= 2'b00;
      tx_q     <= '0;
      ty_q     <= '0;
      d_q      <= '0;
      k_q      <= KW'(1);
      dir_q    <= '0;
      legal_q  <= 1'b0;
      flips_q  <= '0;
      count2_q <= NW'(2);
      count3_q <= NW'(2);
      for (int i = 0; i < N*N; i++) board_q[i] <= initCell(i);
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      k_q      <= k_d;
      dir_q    <= dir_d;
      legal_q  <= legal_d;
      flips_q  <= flips_d;
      count2_q <= count2_d;
      count3_q <= count3_d;
      if (accept) begin
        place_q <= cmd_place;
        side_q  <= side;
        tx_q    <= x;
        ty_q    <= y;
      end
      if (initBoard) begin
        for (int i = 0; i < N*N; i++) board_q[i] <= initCell(i);
      end else if (wrEn) begin
        board_q[wrIdx] <= side_q;
      end
    end
  end

endmodule

// File: tb/tb_othello_board_engine.sv
// Bench for othello_board_engine: a table of hand-derived moves checked through a
// scoreboard queue, plus sequences for busy-input masking, clear and reset mid-flip.
module tb_othello_board_engine;

  localparam int N  = 8;
  localparam int CW = 3;
  localparam int NW = 7;

  logic          clock;
  logic          resetn;
  logic          cmd_valid, cmd_ready, cmd_place, cmd_clear;
  logic [1:0]    side;
  logic [CW-1:0] x, y, rd_x, rd_y;
  logic          done, legal;
  logic [7:0]    dir;
  logic [NW-1:0] flips, count2, count3;
  logic [1:0]    rd_q;

  othello_board_engine #(.N(N)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_place(cmd_place), .cmd_clear(cmd_clear),
    .side(side), .x(x), .y(y),
    .done(done), .legal(legal), .dir(dir), .flips(flips),
    .count2(count2), .count3(count3),
    .rd_x(rd_x), .rd_y(rd_y), .rd_q(rd_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          clr;
    logic          plc;
    logic [1:0]    sd;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          expLegal;
    logic [7:0]    expDir;
    logic [NW-1:0] expFlips;
    logic [NW-1:0] expC2;
    logic [NW-1:0] expC3;
    logic [CW-1:0] rdX;
    logic [CW-1:0] rdY;
    logic [1:0]    expRd;
  } vec_t;

  vec_t vecs [11];
  vec_t sbQ [$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic setVec(input int i, input logic clr, input logic plc, input int sd,
                        input int vx, input int vy, input logic lg, input int dr,
                        input int fl, input int c2, input int c3,
                        input int rx, input int ry, input int rq);
    vecs[i].clr = clr;          vecs[i].plc = plc;          vecs[i].sd = 2'(sd);
    vecs[i].x = CW'(vx);        vecs[i].y = CW'(vy);        vecs[i].expLegal = lg;
    vecs[i].expDir = 8'(dr);    vecs[i].expFlips = NW'(fl);
    vecs[i].expC2 = NW'(c2);    vecs[i].expC3 = NW'(c3);
    vecs[i].rdX = CW'(rx);      vecs[i].rdY = CW'(ry);      vecs[i].expRd = 2'(rq);
  endtask

  function automatic logic [1:0] initialCell(input int cx, input int cy);
    if ((cx == 3 && cy == 3) || (cx == 4 && cy == 4)) return 2'd2;
    if ((cx == 4 && cy == 3) || (cx == 3 && cy == 4)) return 2'd3;
    return 2'd0;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    checkVal("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_clear = v.clr;
    cmd_place = v.plc;
    side      = v.sd;
    x         = v.x;
    y         = v.y;
    sbQ.push_back(v);
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    cmd_place = 1'b0;
  endtask

  task automatic waitDone(input string nm, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      applied++;
      miscompares++;
      $display("[TB] FAIL %s: done never seen, expected within 400 cycles", nm);
    end
  endtask

  task automatic checkOutput(input string nm);
    vec_t e;
    if (sbQ.size() == 0) begin
      applied++;
      miscompares++;
      $display("[TB] FAIL %s: output with empty scoreboard, expected a queued command", nm);
      return;
    end
    e = sbQ.pop_front();
    checkVal({nm, ".legal"},  32'(legal),  32'(e.expLegal));
    checkVal({nm, ".dir"},    32'(dir),    32'(e.expDir));
    checkVal({nm, ".flips"},  32'(flips),  32'(e.expFlips));
    checkVal({nm, ".count2"}, 32'(count2), 32'(e.expC2));
    checkVal({nm, ".count3"}, 32'(count3), 32'(e.expC3));
    rd_x = e.rdX;
    rd_y = e.rdY;
    #1;
    checkVal({nm, ".rd_q"},   32'(rd_q),   32'(e.expRd));
  endtask

  task automatic runVec(input int i);
    bit    ok;
    string nm;
    nm = $sformatf("v%0d", i);
    applyStimulus(vecs[i]);
    waitDone(nm, ok);
    if (ok) checkOutput(nm);
    else    void'(sbQ.pop_front());
  endtask

  task automatic checkBoardInitial(input string nm);
    for (int cy = 0; cy < N; cy++) begin
      for (int cx = 0; cx < N; cx++) begin
        @(negedge clock);
        rd_x = CW'(cx);
        rd_y = CW'(cy);
        #1;
        checkVal($sformatf("%s.cell(%0d,%0d)", nm, cx, cy), 32'(rd_q), 32'(initialCell(cx, cy)));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int doneCount;

    // Moves from the opening position; each row builds on the board left by the previous one.
    //        i  clr   plc   sd x  y  legal dir   fl c2 c3 rx ry rq
    setVec(0,  1'b0, 1'b0, 3, 2, 3, 1'b1, 'h04, 0, 2, 2, 2, 3, 0);
    setVec(1,  1'b0, 1'b1, 3, 2, 3, 1'b1, 'h04, 1, 1, 4, 3, 3, 3);
    setVec(2,  1'b0, 1'b0, 3, 0, 0, 1'b0, 'h00, 0, 1, 4, 0, 0, 0);
    setVec(3,  1'b0, 1'b1, 3, 4, 4, 1'b0, 'h00, 0, 1, 4, 4, 4, 2);
    setVec(4,  1'b0, 1'b1, 2, 7, 2, 1'b0, 'h00, 0, 1, 4, 7, 2, 0);
    setVec(5,  1'b0, 1'b1, 2, 2, 2, 1'b1, 'h08, 1, 3, 3, 3, 3, 2);
    setVec(6,  1'b0, 1'b1, 3, 3, 2, 1'b1, 'h10, 1, 2, 5, 3, 3, 3);
    setVec(7,  1'b0, 1'b0, 2, 2, 4, 1'b1, 'h05, 0, 2, 5, 2, 4, 0);
    setVec(8,  1'b0, 1'b1, 2, 2, 4, 1'b1, 'h05, 2, 5, 3, 3, 4, 2);
    setVec(9,  1'b0, 1'b1, 1, 5, 4, 1'b0, 'h00, 0, 5, 3, 5, 4, 0);
    setVec(10, 1'b1, 1'b0, 0, 0, 0, 1'b0, 'h00, 0, 2, 2, 3, 3, 2);

    resetn = 1'b0;
    cmd_valid = 1'b0; cmd_place = 1'b0; cmd_clear = 1'b0;
    side = 2'd0; x = '0; y = '0; rd_x = '0; rd_y = '0;
    repeat (3) @(negedge clock);

    checkVal("reset.ready",  32'(cmd_ready), 32'd1);
    checkVal("reset.done",   32'(done),      32'd0);
    checkVal("reset.legal",  32'(legal),     32'd0);
    checkVal("reset.dir",    32'(dir),       32'd0);
    checkVal("reset.flips",  32'(flips),     32'd0);
    checkVal("reset.count2", 32'(count2),    32'd2);
    checkVal("reset.count3", 32'(count3),    32'd2);
    resetn = 1'b1;
    checkBoardInitial("reset");

    for (int i = 0; i < 11; i++) runVec(i);
    checkBoardInitial("clear");

    // Inputs change and cmd_valid stays high while busy; only the accepted check may count.
    vecs[0].rdX = CW'(0);
    vecs[0].rdY = CW'(0);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_place = 1'b0; side = 2'd3; x = CW'(2); y = CW'(3);
    sbQ.push_back(vecs[0]);
    @(negedge clock);
    cmd_place = 1'b1; side = 2'd2; x = CW'(0); y = CW'(0);
    doneCount = 0;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0; cmd_place = 1'b0;
    if (ok) begin
      doneCount = 1;
      checkOutput("busy");
      @(negedge clock);
      checkVal("busy.ready_after_done", 32'(cmd_ready), 32'd1);
      if (done === 1'b1) doneCount++;
      for (int n = 0; n < 10; n++) begin
        @(negedge clock);
        if (done === 1'b1) doneCount++;
      end
    end else begin
      void'(sbQ.pop_front());
    end
    checkVal("busy.done_pulses", 32'(doneCount), 32'd1);

    // Rebuild the double-direction position, then reset between the two flips.
    runVec(1);
    runVec(5);
    runVec(6);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_place = 1'b1; side = 2'd2; x = CW'(2); y = CW'(4);
    @(negedge clock);
    cmd_valid = 1'b0; cmd_place = 1'b0;
    rd_x = CW'(2);
    rd_y = CW'(3);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (rd_q === 2'd2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checkVal("midflip.first_flip_seen", 32'(ok), 32'd1);
    resetn = 1'b0;
    #1;
    checkVal("midflip.ready",  32'(cmd_ready), 32'd1);
    checkVal("midflip.done",   32'(done),      32'd0);
    checkVal("midflip.legal",  32'(legal),     32'd0);
    checkVal("midflip.dir",    32'(dir),       32'd0);
    checkVal("midflip.flips",  32'(flips),     32'd0);
    checkVal("midflip.count2", 32'(count2),    32'd2);
    checkVal("midflip.count3", 32'(count3),    32'd2);
    @(negedge clock);
    resetn = 1'b1;
    checkBoardInitial("midflip");
    checkVal("midflip.count2_after", 32'(count2), 32'd2);
    checkVal("midflip.count3_after", 32'(count3), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
